// File: rtl/adc_multi_ch_packer_if.sv
//------------------------------------------------------------------------------
// Module  : adc_multi_ch_packer_if
// Brief   : Sample-input and packed-word-output bus of the ADC packer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface adc_multi_ch_packer_if #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int PACK_N   = 8
);
    logic                                in_valid;
    logic [NUM_CH*SAMPLE_W-1:0]          in_data;
    logic [NUM_CH-1:0]                   in_or;
    logic                                out_valid;
    logic                                out_ready;
    logic [NUM_CH*PACK_N*SAMPLE_W-1:0]   out_data;
    logic [NUM_CH-1:0]                   out_ch_en;
    logic [NUM_CH-1:0]                   out_or;

    // master = sample source / word consumer, slave = packer
    modport master (
        output in_valid, in_data, in_or, out_ready,
        input  out_valid, out_data, out_ch_en, out_or
    );

    modport slave (
        input  in_valid, in_data, in_or, out_ready,
        output out_valid, out_data, out_ch_en, out_or
    );
endinterface

`default_nettype wire

// File: rtl/adc_multi_ch_packer.sv
//------------------------------------------------------------------------------
// Module  : adc_multi_ch_packer
// Brief   : NUM_CH-channel ADC sample decimator/packer with start/stop FSM and
//           one-entry valid/ready hold register. Optional build macro:
//           ADC_PACK_TEST_PATTERN_EN (replace samples by a counter pattern).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module adc_multi_ch_packer #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int PACK_N   = 8
) (
    input  wire logic                 clk_100M,
    input  wire logic                 ch_A_rst_n,
    input  wire logic                 start_sample,
    input  wire logic                 stop_sample,
    input  wire logic [15:0]          dec_cfg,
    input  wire logic [NUM_CH-1:0]    ch_en,
    adc_multi_ch_packer_if.slave      bus,
    output logic                      busy,
    output logic                      overflow,
    output logic                      alg_rst_trig
);

    localparam int c_PW = PACK_N * SAMPLE_W;
    localparam int c_CW = $clog2(PACK_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     r_state;
    logic [15:0]                r_dec_q;
    logic [15:0]                r_dec_cnt;
    logic [NUM_CH-1:0]          r_en_q;
    logic [NUM_CH-1:0]          r_or_acc;
    logic [c_CW-1:0]            r_pack_cnt;
    logic [c_PW-1:0]            r_pack [NUM_CH];
    logic                       r_out_valid;
    logic [NUM_CH*c_PW-1:0]     r_out_data;
    logic [NUM_CH-1:0]          r_out_ch_en;
    logic [NUM_CH-1:0]          r_out_or;
    logic                       r_overflow;
    logic                       r_alg_rst_trig;

    logic [NUM_CH*SAMPLE_W-1:0] w_sample;
    logic [NUM_CH-1:0]          w_or_in;
    logic [c_PW-1:0]            w_next [NUM_CH];
    logic [NUM_CH*c_PW-1:0]     w_word;
    logic                       w_cap;
    logic                       w_done;
    logic                       w_hold_free;

`ifdef ADC_PACK_TEST_PATTERN_EN
    logic [SAMPLE_W-1:0]        r_tp_idx;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_tp
        assign w_sample[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(c << (SAMPLE_W - 4)) + r_tp_idx;
    end
    assign w_or_in = '0;

    always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
        if (!ch_A_rst_n) begin
            r_tp_idx <= '0;
        end else if (r_state == IDLE && start_sample) begin
            r_tp_idx <= '0;
        end else if (w_cap) begin
            r_tp_idx <= r_tp_idx + 1'b1;
        end
    end
`else
    assign w_sample = bus.in_data;
    assign w_or_in  = bus.in_or;
`endif

    // Stop has priority over a coincident beat: the partial word is discarded anyway
    assign w_cap       = (r_state == RUN) && !stop_sample && bus.in_valid && (r_dec_cnt == 16'd0);
    assign w_done      = w_cap && (r_pack_cnt == c_CW'(PACK_N - 1));
    assign w_hold_free = !r_out_valid || bus.out_ready;

    // Disabled channels keep an all-zero pack register
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_next[c] = r_en_q[c] ? {r_pack[c][c_PW-SAMPLE_W-1:0], w_sample[c*SAMPLE_W +: SAMPLE_W]}
                                     : '0;
        assign w_word[c*c_PW +: c_PW] = w_next[c];
    end

    always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
        if (!ch_A_rst_n) begin
            r_state        <= IDLE;
            r_dec_q        <= '0;
            r_dec_cnt      <= '0;
            r_en_q         <= '0;
            r_or_acc       <= '0;
            r_pack_cnt     <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_ch_en    <= '0;
            r_out_or       <= '0;
            r_overflow     <= 1'b0;
            r_alg_rst_trig <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) r_pack[c] <= '0;
        end else begin
            r_alg_rst_trig <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_sample) begin
                        r_state    <= RUN;
                        r_dec_q    <= dec_cfg;
                        r_en_q     <= ch_en;
                        r_overflow <= 1'b0;
                        r_dec_cnt  <= '0;
                        r_pack_cnt <= '0;
                        r_or_acc   <= '0;
                        for (int c = 0; c < NUM_CH; c++) r_pack[c] <= '0;
                    end
                end
                RUN: begin
                    if (stop_sample) begin
                        r_state    <= DRAIN;
                        r_pack_cnt <= '0;
                        r_or_acc   <= '0;
                    end else if (bus.in_valid) begin
                        r_dec_cnt <= (r_dec_q <= 16'd1 || r_dec_cnt == r_dec_q - 16'd1) ? 16'd0
                                                                                      : r_dec_cnt + 16'd1;
                        if (w_cap) begin
                            for (int c = 0; c < NUM_CH; c++) r_pack[c] <= w_next[c];
                            if (w_done) begin
                                r_pack_cnt <= '0;
                                r_or_acc   <= '0;
                            end else begin
                                r_pack_cnt <= r_pack_cnt + 1'b1;
                                r_or_acc   <= r_or_acc | w_or_in;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_hold_free) begin
                        r_state        <= IDLE;
                        r_alg_rst_trig <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A completion into a full, stalled hold register is dropped
            if (w_done) begin
                if (w_hold_free) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_word;
                    r_out_or    <= r_or_acc | w_or_in;
                    r_out_ch_en <= r_en_q;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch_en = r_out_ch_en;
    assign bus.out_or    = r_out_or;
    assign busy          = (r_state != IDLE);
    assign overflow      = r_overflow;
    assign alg_rst_trig  = r_alg_rst_trig;

endmodule

`default_nettype wire

// File: tb/tb_adc_multi_ch_packer.sv
//------------------------------------------------------------------------------
// Module  : tb_adc_multi_ch_packer
// Brief   : Scoreboard bench for adc_multi_ch_packer (directed + random runs).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adc_multi_ch_packer;

    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 16;
    localparam int PACK_N   = 8;
    localparam int PW       = PACK_N * SAMPLE_W;
    localparam int DW       = NUM_CH * PW;

    logic               clk_100M     = 1'b0;
    logic               ch_A_rst_n   = 1'b0;
    logic               start_sample = 1'b0;
    logic               stop_sample  = 1'b0;
    logic [15:0]        dec_cfg      = '0;
    logic [NUM_CH-1:0]  ch_en        = '0;
    logic               busy;
    logic               overflow;
    logic               alg_rst_trig;

    adc_multi_ch_packer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PACK_N(PACK_N)) bus ();

    adc_multi_ch_packer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PACK_N(PACK_N)) dut (
        .clk_100M     (clk_100M),
        .ch_A_rst_n   (ch_A_rst_n),
        .start_sample (start_sample),
        .stop_sample  (stop_sample),
        .dec_cfg      (dec_cfg),
        .ch_en        (ch_en),
        .bus          (bus),
        .busy         (busy),
        .overflow     (overflow),
        .alg_rst_trig (alg_rst_trig)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic [DW-1:0]     data;
        logic [NUM_CH-1:0] orv;
        logic [NUM_CH-1:0] en;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   words_seen = 0;
    int   trig_cnt  = 0;
    logic [DW-1:0]     last_data;
    logic [NUM_CH-1:0] last_or;

    // Reference model: mode 0=idle 1=run 2=drain
    int                m_mode = 0;
    int                m_beat;
    int                m_n;
    int                m_tp;
    logic [15:0]       m_dec;
    logic [NUM_CH-1:0] m_en;
    logic [NUM_CH-1:0] m_or;
    logic [SAMPLE_W-1:0] m_s [NUM_CH][PACK_N];
    bit                m_held = 0;
    bit                m_ovf  = 0;
    bit                m_trig = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [SAMPLE_W-1:0] sample_of(input int c);
`ifdef ADC_PACK_TEST_PATTERN_EN
        return SAMPLE_W'((c << (SAMPLE_W - 4)) + m_tp);
`else
        return bus.in_data[c*SAMPLE_W +: SAMPLE_W];
`endif
    endfunction

    function automatic logic [NUM_CH-1:0] or_of();
`ifdef ADC_PACK_TEST_PATTERN_EN
        return '0;
`else
        return bus.in_or;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently driven
    function automatic void model_step();
        bit   done;
        bit   acc;
        exp_t e;
        done   = 0;
        acc    = m_held && bus.out_ready;
        m_trig = 0;
        case (m_mode)
            0: if (start_sample) begin
                m_mode = 1; m_dec = dec_cfg; m_en = ch_en; m_beat = 0;
                m_n = 0; m_or = '0; m_ovf = 0; m_tp = 0;
            end
            1: if (stop_sample) begin
                m_mode = 2; m_n = 0; m_or = '0;
            end else if (bus.in_valid) begin
                if (m_dec <= 1 || (m_beat % int'(m_dec)) == 0) begin
                    for (int c = 0; c < NUM_CH; c++) m_s[c][m_n] = sample_of(c);
                    m_or = m_or | or_of();
                    m_tp++;
                    m_n++;
                    if (m_n == PACK_N) begin
                        e.data = '0;
                        for (int c = 0; c < NUM_CH; c++)
                            if (m_en[c])
                                for (int k = 0; k < PACK_N; k++)
                                    e.data[c*PW + (PACK_N-1-k)*SAMPLE_W +: SAMPLE_W] = m_s[c][k];
                        e.orv = m_or;
                        e.en  = m_en;
                        done  = 1;
                        m_n   = 0;
                        m_or  = '0;
                    end
                end
                m_beat++;
            end
            default: if (!m_held || bus.out_ready) begin
                m_mode = 0; m_trig = 1;
            end
        endcase
        if (done) begin
            if (!m_held || bus.out_ready) begin
                exp_q.push_back(e);
                m_held = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (acc) begin
            m_held = 0;
        end
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk_100M); #1;
        if (alg_rst_trig) trig_cnt++;
        chk("out_valid", DW'(bus.out_valid), DW'(m_held));
        chk("busy", DW'(busy), DW'(m_mode != 0));
        chk("overflow", DW'(overflow), DW'(m_ovf));
        chk("alg_rst_trig", DW'(alg_rst_trig), DW'(m_trig));
    endtask

    task automatic beat(input logic [NUM_CH*SAMPLE_W-1:0] d, input logic [NUM_CH-1:0] orv);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_or = orv;
        cyc();
        bus.in_valid = 1'b0; bus.in_or = '0;
    endtask

    task automatic do_start(input logic [15:0] dec, input logic [NUM_CH-1:0] en);
        dec_cfg = dec; ch_en = en; start_sample = 1'b1;
        cyc();
        start_sample = 1'b0;
    endtask

    task automatic do_stop();
        stop_sample = 1'b1;
        cyc();
        stop_sample = 1'b0;
    endtask

    task automatic drain_wait();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && m_mode != 0; i++) cyc();
        cyc();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, DW'(bus.out_valid), '0);
        chk({tag, "_out_data"}, bus.out_data, '0);
        chk({tag, "_out_or"}, DW'(bus.out_or), '0);
        chk({tag, "_out_ch_en"}, DW'(bus.out_ch_en), '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_overflow"}, DW'(overflow), '0);
        chk({tag, "_alg_rst_trig"}, DW'(alg_rst_trig), '0);
    endtask

    // Monitor: a word is consumed on every valid&ready clock
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100M);
            if (ch_A_rst_n && bus.out_valid && bus.out_ready) begin
                words_seen++;
                last_data = bus.out_data;
                last_or   = bus.out_or;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %0h required none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_or", DW'(bus.out_or), DW'(e.orv));
                    chk("out_ch_en", DW'(bus.out_ch_en), DW'(e.en));
                end
            end
        end
    end

    initial begin
        int            w0;
        int            t0;
        int            len;
        logic [127:0]  ref_ch;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_or     = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk_100M);
        #1;
        check_all_zero("reset");
        ch_A_rst_n = 1'b1;
        cyc();

        // Basic packing, newest sample in the LSBs
        bus.out_ready = 1'b1;
        w0 = words_seen;
        do_start(16'd1, 2'b11);
        for (int i = 1; i <= PACK_N; i++) beat({16'(16'h100 + i), 16'(i)}, 2'b00);
        cyc(); cyc();
        chk("t1_words", DW'(words_seen - w0), DW'(1));
        chk("t1_ch0", DW'(last_data[127:0]), DW'(128'h0001_0002_0003_0004_0005_0006_0007_0008));
        chk("t1_ch1", DW'(last_data[255:128]), DW'(128'h0101_0102_0103_0104_0105_0106_0107_0108));
        do_stop();
        drain_wait();

        // Decimation by 20
        w0 = words_seen;
        do_start(16'd20, 2'b11);
        for (int i = 0; i < 160; i++) beat({16'($urandom), 16'(i)}, 2'b00);
        cyc(); cyc();
        ref_ch = '0;
        for (int k = 0; k < PACK_N; k++) ref_ch[(PACK_N-1-k)*SAMPLE_W +: SAMPLE_W] = 16'(20 * k);
        chk("t2_words", DW'(words_seen - w0), DW'(1));
        chk("t2_ch0", DW'(last_data[127:0]), DW'(ref_ch));
        do_stop();
        drain_wait();

        // Stalled consumer: second word dropped, overflow sticky until restart
        bus.out_ready = 1'b0;
        do_start(16'd0, 2'b11);
        for (int i = 0; i < 2*PACK_N; i++) beat(32'($urandom), 2'b00);
        cyc(); cyc(); cyc();
        chk("t3_overflow", DW'(overflow), DW'(1));
        bus.out_ready = 1'b1;
        cyc(); cyc();
        do_stop();
        drain_wait();
        do_start(16'd1, 2'b11);
        chk("t3_ovf_clear", DW'(overflow), DW'(0));
        do_stop();
        drain_wait();

        // Stop after a partial word
        w0 = words_seen;
        t0 = trig_cnt;
        do_start(16'd1, 2'b11);
        for (int i = 0; i < 5; i++) beat(32'($urandom), 2'b00);
        do_stop();
        drain_wait();
        chk("t4_words", DW'(words_seen - w0), DW'(0));
        chk("t4_trig", DW'(trig_cnt - t0), DW'(1));

        // Stop with a held word and a stalled consumer
        bus.out_ready = 1'b0;
        do_start(16'd1, 2'b11);
        for (int i = 0; i < PACK_N; i++) beat(32'($urandom), 2'b00);
        do_stop();
        repeat (10) cyc();
        drain_wait();

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            do_start(16'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
            len = $urandom_range(20, 150);
            for (int i = 0; i < len; i++) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_data   = 32'($urandom);
                bus.in_or     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                bus.out_ready = ($urandom_range(0, 3) != 0);
                dec_cfg       = 16'($urandom);
                start_sample  = ($urandom_range(0, 31) == 0);
                cyc();
            end
            bus.in_valid = 1'b0; bus.in_or = '0; start_sample = 1'b0;
            bus.out_ready = 1'($urandom_range(0, 1));
            do_stop();
            drain_wait();
        end

        // Disabled channel, overrange accumulation, then reset mid-word
        bus.out_ready = 1'b1;
        do_start(16'd1, 2'b01);
        for (int i = 1; i <= PACK_N; i++) beat(32'($urandom), (i == 3) ? 2'b01 : 2'b00);
        cyc(); cyc();
        chk("t6_ch1_zero", DW'(last_data[255:128]), '0);
        chk("t6_or", DW'(last_or), DW'(2'b01));
        for (int i = 0; i < 3; i++) beat(32'($urandom), 2'b00);
        #3 ch_A_rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        m_mode = 0; m_held = 0; m_ovf = 0; m_trig = 0; m_n = 0;
        exp_q.delete();
        @(posedge clk_100M); #1;
        ch_A_rst_n = 1'b1;
        repeat (3) cyc();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_words: got %0d required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
